// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop consume one operand
// bit per clock, LSB first, under a start/done handshake.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] MSB_BIT  = CW'(WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, sum_sr_q;
  logic [WIDTH-1:0] sum_sr_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, carry_d;
  logic             bit_d;
  logic             msb_cin_q;
  logic             busy_q, done_q, cout_q, ovf_q;
  logic [WIDTH-1:0] sum_q;

  // Full-adder cell on the current LSBs.
  assign bit_d    = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
  assign carry_d  = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
  assign sum_sr_d = {bit_d, sum_sr_q[WIDTH-1:1]};

  // NOTE: all state is assigned with <= so every flop samples pre-edge values;
  // reset is synchronous, so it lives inside the clocked branch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      sum_sr_q  <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      msb_cin_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q  <= RUN;
            busy_q   <= 1'b1;
            a_sr_q   <= a;
            b_sr_q   <= b;
            carry_q  <= cin;
            cnt_q    <= '0;
          end else begin
            state_q  <= IDLE;
          end
        end
        RUN: begin
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          sum_sr_q <= sum_sr_d;
          carry_q  <= carry_d;
          cnt_q    <= cnt_q + CW'(1);
          // Carry out of bit WIDTH-2 is the carry into the MSB.
          if (cnt_q == MSB_BIT) msb_cin_q <= carry_d;
          if (cnt_q == LAST_BIT) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            sum_q   <= sum_sr_d;
            cout_q  <= carry_d;
            ovf_q   <= msb_cin_q ^ carry_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed handshake/timing scenarios on
// an 8-bit instance plus randomized sums on 8- and 16-bit instances.
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start8 = 1'b0, cin8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;

  logic        start16 = 1'b0, cin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] sum16;

  int vectors = 0;
  int miscompares = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer addition; overflow when both operands share a
  // sign that the result does not.
  function automatic logic [17:0] model(input int w, input logic [15:0] x, y, input logic c);
    logic [16:0] full;
    logic [15:0] s;
    logic        co, ov;
    full = {1'b0, x} + {1'b0, y} + 17'(c);
    s    = full[15:0] & 16'((17'd1 << w) - 17'd1);
    co   = full[w];
    ov   = (x[w-1] == y[w-1]) && (s[w-1] != x[w-1]);
    return {ov, co, s};
  endfunction

  // Called in cycle cyc0 of an operation; returns the cycle in which done rose.
  task automatic wait_done8(input int cyc0, output int cyc, output int busy_cycles);
    cyc = cyc0;
    busy_cycles = 0;
    while (!done8 && cyc < 40) begin
      if (busy8) busy_cycles++;
      tick();
      cyc++;
    end
  endtask

  task automatic op8(input logic [7:0] x, y, input logic c, input string name);
    logic [17:0] exp;
    int cyc, bc;
    exp = model(8, {8'h00, x}, {8'h00, y}, c);
    start8 = 1'b1; a8 = x; b8 = y; cin8 = c;
    tick();
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    vectors++;
    wait_done8(1, cyc, bc);
    if (cyc !== 9) begin
      miscompares++; $display("FAIL %s latency: done in cycle %0d, expected 9", name, cyc);
    end
    if (bc !== 8) begin
      miscompares++; $display("FAIL %s busy: high %0d cycles, expected 8", name, bc);
    end
    if (busy8 !== 1'b0) begin
      miscompares++; $display("FAIL %s busy_with_done: busy=%b, expected 0", name, busy8);
    end
    if ({ovf8, cout8, sum8} !== {exp[17], exp[16], exp[7:0]}) begin
      miscompares++;
      $display("FAIL %s result: sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
               name, sum8, cout8, ovf8, exp[7:0], exp[16], exp[17]);
    end
    tick();
    if (done8 !== 1'b0) begin
      miscompares++; $display("FAIL %s done_width: done=%b one cycle later, expected 0", name, done8);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset8: busy=%b done=%b sum=%h cout=%b ovf=%b, expected all 0",
               busy8, done8, sum8, cout8, ovf8);
    end
    if ({busy16, done16, sum16, cout16, ovf16} !== 20'h00000) begin
      miscompares++;
      $display("FAIL reset16: busy=%b done=%b sum=%h cout=%b ovf=%b, expected all 0",
               busy16, done16, sum16, cout16, ovf16);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    op8(8'h3C, 8'h0F, 1'b0, "add_3c_0f");
    op8(8'hFF, 8'h01, 1'b0, "add_ff_01");
    op8(8'h7F, 8'h01, 1'b0, "add_7f_01");
  endtask

  task automatic test_hold();
    op8(8'h80, 8'h80, 1'b1, "add_80_80_c");
    for (int i = 0; i < 5; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom);
      if ({ovf8, cout8, sum8} !== {1'b1, 1'b1, 8'h01}) begin
        miscompares++;
        $display("FAIL hold%0d: sum=%h cout=%b ovf=%b, expected sum=01 cout=1 ovf=1",
                 i, sum8, cout8, ovf8);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bc;
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    // Cycle 4: a start here must be ignored.
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    tick();
    start8 = 1'b0;
    vectors++;
    wait_done8(5, cyc, bc);
    if (cyc !== 9 || sum8 !== 8'h30 || cout8 !== 1'b0 || ovf8 !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_start: done cycle %0d sum=%h cout=%b ovf=%b, expected cycle 9 sum=30 0 0",
               cyc, sum8, cout8, ovf8);
    end
    // Start held from the DONE cycle onward: every DONE accepts a new add.
    start8 = 1'b1; a8 = 8'h01; b8 = 8'h02; cin8 = 1'b1;
    tick();
    if (busy8 !== 1'b1) begin
      miscompares++; $display("FAIL b2b_start: busy=%b right after DONE, expected 1", busy8);
    end
    vectors++;
    wait_done8(1, cyc, bc);
    if (cyc !== 9 || bc !== 8 || sum8 !== 8'h04) begin
      miscompares++;
      $display("FAIL b2b_second: done cycle %0d busy %0d sum=%h, expected cycle 9 busy 8 sum=04",
               cyc, bc, sum8);
    end
    tick();
    start8 = 1'b0;
    vectors++;
    wait_done8(1, cyc, bc);
    if (cyc !== 9 || sum8 !== 8'h04) begin
      miscompares++;
      $display("FAIL b2b_held: done cycle %0d sum=%h, expected cycle 9 sum=04", cyc, sum8);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    int seen;
    start8 = 1'b1; a8 = 8'h55; b8 = 8'hAA; cin8 = 1'b0;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick(); tick();
    // Cycle 5: reset for one edge, with start also high to test priority.
    rst_n = 1'b0; start8 = 1'b1;
    tick();
    rst_n = 1'b1; start8 = 1'b0;
    if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin
      miscompares++;
      $display("FAIL abort_outputs: busy=%b done=%b sum=%h cout=%b ovf=%b, expected all 0",
               busy8, done8, sum8, cout8, ovf8);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done8 || busy8) seen++;
      tick();
    end
    if (seen !== 0) begin
      miscompares++; $display("FAIL abort_quiet: busy/done high in %0d cycles after reset, expected 0", seen);
    end
    op8(8'h55, 8'hAA, 1'b0, "after_abort");
  endtask

  task automatic test_random();
    logic [7:0]  ra8, rb8;
    logic [15:0] ra16, rb16;
    logic        rc8, rc16;
    logic [17:0] e8, e16;
    bit          got8, got16;
    int          cyc;
    for (int n = 0; n < 1000; n++) begin
      ra8 = 8'($urandom); rb8 = 8'($urandom); rc8 = 1'($urandom);
      ra16 = 16'($urandom); rb16 = 16'($urandom); rc16 = 1'($urandom);
      e8  = model(8, {8'h00, ra8}, {8'h00, rb8}, rc8);
      e16 = model(16, ra16, rb16, rc16);
      start8 = 1'b1; a8 = ra8; b8 = rb8; cin8 = rc8;
      start16 = 1'b1; a16 = ra16; b16 = rb16; cin16 = rc16;
      tick();
      start8 = 1'b0; start16 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
      vectors += 2;
      got8 = 1'b0; got16 = 1'b0; cyc = 1;
      while (!(got8 && got16) && cyc < 40) begin
        if (done8 && !got8) begin
          got8 = 1'b1;
          if (cyc !== 9 || {ovf8, cout8, sum8} !== {e8[17], e8[16], e8[7:0]}) begin
            miscompares++;
            $display("FAIL rand8 #%0d %h+%h+%b: cycle %0d sum=%h cout=%b ovf=%b, expected cycle 9 sum=%h cout=%b ovf=%b",
                     n, ra8, rb8, rc8, cyc, sum8, cout8, ovf8, e8[7:0], e8[16], e8[17]);
          end
        end
        if (done16 && !got16) begin
          got16 = 1'b1;
          if (cyc !== 17 || {ovf16, cout16, sum16} !== {e16[17], e16[16], e16[15:0]}) begin
            miscompares++;
            $display("FAIL rand16 #%0d %h+%h+%b: cycle %0d sum=%h cout=%b ovf=%b, expected cycle 17 sum=%h cout=%b ovf=%b",
                     n, ra16, rb16, rc16, cyc, sum16, cout16, ovf16, e16[15:0], e16[16], e16[17]);
          end
        end
        tick();
        cyc++;
      end
      if (!got8 || !got16) begin
        miscompares++;
        $display("FAIL rand_timeout #%0d: done8 seen=%b done16 seen=%b, expected both", n, got8, got16);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial N-bit adder: one full-adder cell plus a carry flip-flop process one operand bit per clock, LSB first, under a start/done handshake. It is the additive counterpart of the team's full-subtractor cell and sits beside the arithmetic primitives as a low-area, multi-cycle adder. Results and flags are held stable after completion until the next accepted start.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range is 2 or more.

- `clk`  in  1  Single clock; all state updates on the rising edge.
- `rst_n`  in  1  Synchronous reset, active-low; sampled on the rising edge of `clk`.
- `start`  in  1  Request a new addition; sampled on the rising edge.
- `a`  in  WIDTH  Operand A; captured only on an accepted start.
- `b`  in  WIDTH  Operand B; captured only on an accepted start.
- `cin`  in  1  Carry-in; captured only on an accepted start.
- `busy`  out  1  High while bits are being processed.
- `done`  out  1  One-cycle pulse: `sum`, `cout` and `ovf` are valid.
- `sum`  out  WIDTH  Result, equal to (a + b + cin) mod 2^WIDTH.
- `cout`  out  1  Carry out of the MSB.
- `ovf`  out  1  Two's-complement overflow: carry into the MSB XOR `cout`.

## Operation
- Reset (`rst_n`=0 at an edge): state←IDLE; `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0; internal shift registers, carry and bit counter cleared.
- States:
  - IDLE: waits for `start`.
  - RUN: processes one bit per cycle.
  - DONE: lasts exactly one cycle.
- IDLE→RUN when `start`=1:
  - `a` and `b` are loaded into right-shift registers.
  - The carry flip-flop is loaded with `cin`.
  - The bit counter is set to 0.
- Each RUN cycle, with bit i = counter value:
  - s = a_sr[0] ^ b_sr[0] ^ c
  - c_next = (a_sr[0]&b_sr[0]) | (a_sr[0]&c) | (b_sr[0]&c)
  - The sum shift register shifts right and inserts s at the MSB.
  - a_sr and b_sr shift right.
  - The counter increments.
  - On bit WIDTH-2, the incoming carry of the MSB is captured for `ovf`.
- RUN→DONE after bit WIDTH-1 is processed:
  - `sum` ← the full sum shift register.
  - `cout` ← c_next.
  - `ovf` ← captured MSB carry-in XOR c_next.
- DONE→RUN if `start`=1 in that cycle (back-to-back operation); otherwise DONE→IDLE.
- `start` during RUN is ignored; there is no queuing and no effect on the operation in progress.
- `sum`, `cout` and `ovf` update only on the RUN→DONE transition and hold through IDLE and any following RUN.
- Operand inputs are don't-care except in the accepting cycle.

## Timing
- Start accepted at edge 0.
- `busy`=1 during cycles 1..WIDTH.
- `done`=1 during cycle WIDTH+1, with outputs valid in that same cycle.
- Latency from start to done: WIDTH+1 cycles.
- Throughput: one addition per WIDTH+1 cycles when `start` is asserted during DONE.
- `busy` and `done` are never high together.
- `done` is exactly one cycle wide.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset asserted mid-RUN aborts the operation at that edge:
  - All outputs read 0 on the next cycle.
  - No `done` is issued.
  - Reset has priority over `start`.
- `start` held continuously high: a new operation is accepted every DONE cycle.

## Test plan
- WIDTH=8, a=0x3C, b=0x0F, cin=0, one-cycle start → `busy` high for 8 cycles; `done` at cycle 9 with `sum`=0x4B, `cout`=0, `ovf`=0.
- a=0xFF, b=0x01, cin=0 → `sum`=0x00, `cout`=1, `ovf`=0; then a=0x7F, b=0x01, cin=0 → `sum`=0x80, `cout`=0, `ovf`=1.
- a=0x80, b=0x80, cin=1 → `sum`=0x01, `cout`=1, `ovf`=1; results remain held 5 idle cycles after `done`.
- Start with a=0x10, b=0x20; pulse `start` with a=0xFF, b=0xFF at cycle 4 → pulse ignored; `done` at cycle 9 with `sum`=0x30; `start` held during DONE → second run begins at once, `done` 9 cycles later.
- Start a=0x55, b=0xAA; drive `rst_n`=0 at cycle 5 for one edge → all outputs 0, no `done`; a new start afterwards completes with correct `sum`=0xFF.
- Randomized regression (1000 vectors, WIDTH=8 and WIDTH=16) → `sum`, `cout` and `ovf` match the reference model a+b+cin on every `done`.
